// File: rtl/mdio_responder_pkg.sv
// Shared constants and state encoding for the Clause-22 MDIO responder.
package mdio_responder_pkg;
  localparam int SYNC_DEPTH = 2;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA
  } state_t;
endpackage

// File: rtl/mdio_responder_if.sv
// Register-side bus of the MDIO responder: address, read/write strobes and data.
interface mdio_responder_if;
  logic [4:0]  reg_addr;
  logic        reg_rd_stb;
  logic [15:0] reg_rd_data;
  logic        reg_wr_stb;
  logic [15:0] reg_wr_data;

  modport master (output reg_addr, reg_rd_stb, reg_wr_stb, reg_wr_data, input reg_rd_data);
  modport slave  (input reg_addr, reg_rd_stb, reg_wr_stb, reg_wr_data, output reg_rd_data);
endinterface

// File: rtl/mdio_sync.sv
// Synchronizes MDC and MDIO into the system clock and flags MDC rising edges.
module mdio_sync
  import mdio_responder_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic mdc,
  input  logic mdio,
  output logic tick,
  output logic mdio_s
);
  logic [SYNC_DEPTH-1:0] mdc_ff, mdio_ff;
  logic                  mdc_prev;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mdc_ff   <= '0;
      mdio_ff  <= '0;
      mdc_prev <= 1'b0;
    end else begin
      mdc_ff   <= {mdc_ff[SYNC_DEPTH-2:0], mdc};
      mdio_ff  <= {mdio_ff[SYNC_DEPTH-2:0], mdio};
      mdc_prev <= mdc_ff[SYNC_DEPTH-1];
    end
  end

  // Both paths have equal depth, so mdio_s is the bit present at the MDC edge.
  assign tick   = mdc_ff[SYNC_DEPTH-1] & ~mdc_prev;
  assign mdio_s = mdio_ff[SYNC_DEPTH-1];
endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: decodes frames on MDC ticks and drives a register bus.
module mdio_responder
  import mdio_responder_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         MIN_PREAMBLE = 32
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic mdc,
  input  logic mdio_i,
  output logic mdio_o,
  output logic mdio_t,
  mdio_responder_if.master bus
);
  localparam logic [5:0] MIN_CNT = 6'(MIN_PREAMBLE);

  logic        tick, din;
  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [4:0]  bcnt, bcnt_n;
  logic        rd, rd_n;
  logic [4:0]  addr, addr_n;
  logic [15:0] sr, sr_n;
  logic        o, o_n, t, t_n;
  logic        rd_stb, rd_stb_n, wr_stb, wr_stb_n;
  logic [15:0] wr_data, wr_data_n;

  mdio_sync u_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .mdc      (mdc),
    .mdio     (mdio_i),
    .tick     (tick),
    .mdio_s   (din)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bcnt    <= '0;
      rd      <= 1'b0;
      addr    <= '0;
      sr      <= '0;
      o       <= 1'b0;
      t       <= 1'b1;
      rd_stb  <= 1'b0;
      wr_stb  <= 1'b0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bcnt    <= bcnt_n;
      rd      <= rd_n;
      addr    <= addr_n;
      sr      <= sr_n;
      o       <= o_n;
      t       <= t_n;
      rd_stb  <= rd_stb_n;
      wr_stb  <= wr_stb_n;
      wr_data <= wr_data_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bcnt_n    = bcnt;
    rd_n      = rd;
    addr_n    = addr;
    sr_n      = sr;
    o_n       = o;
    t_n       = t;
    rd_stb_n  = 1'b0;
    wr_stb_n  = 1'b0;
    wr_data_n = wr_data;
    // Read data arrives one cycle after the strobe; ticks never coincide with it.
    if (rd_stb) sr_n = bus.reg_rd_data;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (din) begin
            if (cnt != 6'h3f) cnt_n = cnt + 6'd1;
          end else begin
            cnt_n = '0;
            if (cnt >= MIN_CNT) state_n = S_ST;
          end
        end
        S_ST: begin
          bcnt_n  = '0;
          state_n = din ? S_OP : S_IDLE;
        end
        S_OP: begin
          sr_n = {sr[14:0], din};
          if (bcnt[0]) begin
            bcnt_n = '0;
            case ({sr[0], din})
              OP_READ:  begin rd_n = 1'b1; state_n = S_PHYAD; end
              OP_WRITE: begin rd_n = 1'b0; state_n = S_PHYAD; end
              default:  state_n = S_IDLE;
            endcase
          end else bcnt_n = bcnt + 5'd1;
        end
        S_PHYAD: begin
          sr_n = {sr[14:0], din};
          if (bcnt == 5'd4) begin
            bcnt_n  = '0;
            state_n = ({sr[3:0], din} == PHY_ADDR) ? S_REGAD : S_IDLE;
          end else bcnt_n = bcnt + 5'd1;
        end
        S_REGAD: begin
          addr_n = {addr[3:0], din};
          if (bcnt == 5'd4) begin
            bcnt_n   = '0;
            rd_stb_n = rd;
            state_n  = S_TA;
          end else bcnt_n = bcnt + 5'd1;
        end
        S_TA: begin
          if (bcnt == 5'd0) bcnt_n = 5'd1;
          else begin
            bcnt_n = '0;
            if (rd) begin
              t_n     = 1'b0;
              o_n     = 1'b0;
              state_n = S_RDATA;
            end else state_n = S_WDATA;
          end
        end
        S_RDATA: begin
          // Ticks 1..16 present bits MSB first; the 17th releases the line.
          if (bcnt == 5'd16) begin
            bcnt_n  = '0;
            t_n     = 1'b1;
            o_n     = 1'b0;
            state_n = S_IDLE;
          end else begin
            o_n    = sr[15];
            sr_n   = {sr[14:0], 1'b0};
            bcnt_n = bcnt + 5'd1;
          end
        end
        S_WDATA: begin
          sr_n = {sr[14:0], din};
          if (bcnt == 5'd15) begin
            bcnt_n    = '0;
            wr_data_n = {sr[14:0], din};
            wr_stb_n  = 1'b1;
            state_n   = S_IDLE;
          end else bcnt_n = bcnt + 5'd1;
        end
      endcase
    end
  end

  assign mdio_o          = o;
  assign mdio_t          = t;
  assign bus.reg_addr    = addr;
  assign bus.reg_rd_stb  = rd_stb;
  assign bus.reg_wr_stb  = wr_stb;
  assign bus.reg_wr_data = wr_data;
endmodule

// File: tb/tb_mdio_responder.sv
// Frame-level bench: a MAC model drives MDC/MDIO, a frame predicate plus drive map is the reference.
module tb_mdio_responder;
  import mdio_responder_pkg::*;

  localparam logic [4:0] PHY  = 5'd1;
  localparam int         MINP = 32;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0, mdc = 1'b0, mac_bit = 1'b1;
  logic mdio_i, mdio_o, mdio_t;
  int   total = 0, bad = 0;

  logic [15:0] regfile [32];
  int          rd_pulses = 0, rd_high = 0, wr_pulses = 0, wr_high = 0;
  logic [4:0]  rd_addr_seen, wr_addr_seen;
  logic [15:0] wr_data_seen;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;

  mdio_responder_if bus();

  mdio_responder #(.PHY_ADDR(PHY), .MIN_PREAMBLE(MINP)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .mdc      (mdc),
    .mdio_i   (mdio_i),
    .mdio_o   (mdio_o),
    .mdio_t   (mdio_t),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Pad: the responder wins when driving, otherwise the MAC (or pull-up) value.
  assign mdio_i = mdio_t ? mac_bit : mdio_o;

  // Register-file side: counts strobes and answers reads only in the cycle after the strobe.
  initial begin
    bus.reg_rd_data = '0;
    forever begin
      @(negedge sys_clk);
      if (bus.reg_rd_stb) begin
        rd_high++;
        if (!prev_rd) begin rd_pulses++; rd_addr_seen = bus.reg_addr; end
      end
      if (bus.reg_wr_stb) begin
        wr_high++;
        if (!prev_wr) begin
          wr_pulses++; wr_addr_seen = bus.reg_addr; wr_data_seen = bus.reg_wr_data;
        end
      end
      prev_rd = bus.reg_rd_stb;
      prev_wr = bus.reg_wr_stb;
      bus.reg_rd_data = bus.reg_rd_stb ? regfile[bus.reg_addr] : 16'($urandom);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  // One MDC period: MAC changes data on the falling edge, the pad is judged just before the rise.
  task automatic period(input logic b, input logic et, input logic eo, input logic do_rst,
                        output logic seen);
    mdc = 1'b0;
    mac_bit = b;
    if (do_rst) begin
      #20 sys_rst_n = 1'b0;
      #1;
      chk("rst_mdio_t", 32'(mdio_t), 32'd1);
      chk("rst_mdio_o", 32'(mdio_o), 32'd0);
      chk("rst_stb", {30'd0, bus.reg_rd_stb, bus.reg_wr_stb}, 32'd0);
      #29 sys_rst_n = 1'b1;
      #30;
    end else #80;
    if (et) chk("pad_released", 32'(mdio_t), 32'd1);
    else begin
      chk("pad_driven", 32'(mdio_t), 32'd0);
      chk("pad_value", 32'(mdio_o), 32'(eo));
    end
    seen = mdio_o;
    mdc = 1'b1;
    #80;
  endtask

  // Reference: a frame is answered iff preamble, opcode and PHY address all qualify.
  // An answered read shows TA 0 before tick pre+17, then data MSB first before ticks pre+18..pre+33.
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input int rst_at,
                       output logic [15:0] rdata);
    logic [31:0] body;
    logic        ans, is_rd, is_wr, et, eo, s, b;
    logic [15:0] rv;
    int          n, rp0, rh0, wp0, wh0, post0;
    ans   = (pre >= MINP) && (op == OP_READ || op == OP_WRITE) && (phy == PHY);
    is_rd = ans && (op == OP_READ);
    is_wr = ans && (op == OP_WRITE);
    rv    = regfile[ra];
    body  = {2'b01, op, phy, ra, (op == OP_READ) ? 18'h3ffff : {2'b10, wd}};
    n     = pre + 33;
    rp0 = rd_pulses; rh0 = rd_high; wp0 = wr_pulses; wh0 = wr_high;
    post0 = 0;
    rdata = '0;
    for (int k = 1; k <= n; k++) begin
      b  = (k <= pre) ? 1'b1 : (k <= pre + 32) ? body[pre + 32 - k] : 1'b0;
      et = 1'b1;
      eo = 1'b0;
      if (is_rd && (rst_at == 0 || k < rst_at)) begin
        if (k == pre + 17) et = 1'b0;
        else if (k >= pre + 18) begin et = 1'b0; eo = rv[pre + 33 - k]; end
      end
      period(b, et, eo, k == rst_at, s);
      if (k == rst_at) post0 = rd_pulses + wr_pulses;
      if (k >= pre + 18 && !et) rdata[pre + 33 - k] = s;
    end
    chk("rd_count", 32'(rd_pulses - rp0), 32'(is_rd));
    chk("rd_width", 32'(rd_high - rh0), 32'(is_rd));
    chk("wr_count", 32'(wr_pulses - wp0), 32'(is_wr));
    chk("wr_width", 32'(wr_high - wh0), 32'(is_wr));
    if (is_rd) chk("rd_addr", 32'(rd_addr_seen), 32'(ra));
    if (is_wr) begin
      chk("wr_addr", 32'(wr_addr_seen), 32'(ra));
      chk("wr_data", 32'(wr_data_seen), 32'(wd));
    end
    if (rst_at != 0) chk("post_rst_stb", 32'(rd_pulses + wr_pulses - post0), 32'd0);
  endtask

  logic [15:0] got;
  logic        s_end;
  int          pr;
  logic [1:0]  rop;
  logic [4:0]  rph, rra;
  logic [15:0] rwd;

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 16'($urandom);
    repeat (4) @(negedge sys_clk);
    chk("reset_mdio_t", 32'(mdio_t), 32'd1);
    chk("reset_mdio_o", 32'(mdio_o), 32'd0);
    chk("reset_addr", 32'(bus.reg_addr), 32'd0);
    chk("reset_wr_data", 32'(bus.reg_wr_data), 32'd0);
    chk("reset_stbs", {30'd0, bus.reg_rd_stb, bus.reg_wr_stb}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Basic read of register 2.
    regfile[2] = 16'h0141;
    frame(32, OP_READ, 5'd1, 5'h02, 16'h0000, 0, got);
    chk("lit_rd_word", 32'(got), 32'h0141);
    chk("lit_rd_addr", 32'(rd_addr_seen), 32'h02);

    // Basic write of 0x8000 to register 0.
    frame(32, OP_WRITE, 5'd1, 5'h00, 16'h8000, 0, got);
    chk("lit_wr_data", 32'(wr_data_seen), 32'h8000);
    chk("lit_wr_addr", 32'(wr_addr_seen), 32'h00);

    // Foreign PHY address, short preamble, bad opcode, each followed by a good frame.
    frame(32, OP_READ, 5'd3, 5'h04, 16'h0000, 0, got);
    frame(31, OP_READ, 5'd1, 5'h05, 16'h0000, 0, got);
    frame(32, OP_READ, 5'd1, 5'h05, 16'h0000, 0, got);
    chk("lit_rd_after_short", 32'(got), 32'(regfile[5]));
    frame(32, 2'b11, 5'd1, 5'h06, 16'h1234, 0, got);
    frame(32, OP_READ, 5'd1, 5'h07, 16'h0000, 0, got);

    // Reset while RDATA bit 8 is on the wire, then a clean frame.
    frame(32, OP_READ, 5'd1, 5'h09, 16'h0000, 32 + 25, got);
    frame(32, OP_READ, 5'd1, 5'h09, 16'h0000, 0, got);
    chk("lit_rd_after_rst", 32'(got), 32'(regfile[9]));

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0:       pr = 31;
        1:       pr = 32;
        default: pr = 32 + int'($urandom_range(0, 6));
      endcase
      rop = 2'($urandom);
      rph = ($urandom_range(0, 2) != 0) ? PHY : 5'($urandom);
      rra = 5'($urandom);
      rwd = 16'($urandom);
      frame(pr, rop, rph, rra, rwd, 0, got);
    end

    period(1'b1, 1'b1, 1'b0, 1'b0, s_end);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 Parameter PHY_ADDR, default 5'd1: Clause-22 PHY address this responder answers.
REQ-002 Parameter MIN_PREAMBLE, default 32: consecutive 1 bits required before a start-of-frame.
REQ-003 SYS_CLK  in  1  sole clock; MDC is sampled in this domain (SYS_CLK at least 8x MDC).
REQ-004 SYS_RST_N  in  1  asynchronous, active-low reset.
REQ-005 MDC  in  1  management clock from the MAC; asynchronous, sampled.
REQ-006 MDIO_I  in  1  MDIO pad input, taken from the IOBUF O pin.
REQ-007 MDIO_O  out  1  MDIO drive value, going to the IOBUF I pin.
REQ-008 MDIO_T  out  1  IOBUF tristate control; 1 = released (high-Z).
REQ-009 REG_ADDR  out  5  register address of the current frame.
REQ-010 REG_RD_STB  out  1  one-cycle read request.
REQ-011 REG_RD_DATA  in  16  read data; sampled exactly 1 SYS_CLK after REG_RD_STB.
REQ-012 REG_WR_STB  out  1  one-cycle write strobe.
REQ-013 REG_WR_DATA  out  16  write data; valid while REG_WR_STB=1.

Function
REQ-014 MDC and MDIO_I SHALL each pass through a 2-flop synchronizer; an MDC rising edge ("tick") is synced MDC=1 with its previous value 0; all bit sampling SHALL occur on ticks.
REQ-015 Tick-to-drive latency: MDIO_O/MDIO_T SHALL update 1 SYS_CLK after the tick.
REQ-016 States: IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA.
REQ-017 IDLE: a saturating 6-bit counter SHALL count consecutive 1s; a 0 with count >= MIN_PREAMBLE SHALL go to ST; a 0 with count < MIN_PREAMBLE SHALL clear the count.
REQ-018 ST: bit 1 -> OP; bit 0 -> IDLE with count cleared.
REQ-019 OP: 2 bits, MSB first; 10 = read, 01 = write; 00/11 -> IDLE with count cleared.
REQ-020 PHYAD: 5 bits MSB first; on mismatch with PHY_ADDR -> IDLE with count cleared, no strobes, MDIO_T stays 1.
REQ-021 REGAD: 5 bits MSB first into REG_ADDR; for a read, REG_RD_STB SHALL pulse in the cycle after the 5th tick and REG_RD_DATA SHALL be latched into a 16-bit shift register one cycle later.
REQ-022 TA read: 1st tick keeps MDIO_T=1; 2nd tick drives MDIO_T=0, MDIO_O=0; then -> RDATA.
REQ-023 TA write: 2 ticks, both bits ignored, MDIO_T=1; then -> WDATA.
REQ-024 RDATA: each of 16 ticks SHALL present the next data bit, MSB first; the tick after bit 0 SHALL set MDIO_T=1 and go to IDLE with count 0.
REQ-025 WDATA: shift in 16 bits MSB first; in the cycle after the 16th tick, REG_WR_STB SHALL pulse once with REG_WR_DATA/REG_ADDR stable; -> IDLE.
REQ-026 MDIO_T SHALL be 0 only from the 2nd read-TA bit through RDATA bit 0; otherwise it is 1.
REQ-027 Strobes SHALL last exactly one SYS_CLK cycle; at most one strobe per frame.

Reset
REQ-028 While SYS_RST_N=0: state IDLE, count 0, MDIO_T=1, MDIO_O=0, REG_ADDR=0, REG_WR_DATA=0, both strobes 0, synchronizers 0.
REQ-029 A reset assertion during RDATA SHALL release MDIO immediately and produce no strobe; after release, a full preamble is required.

Structure
REQ-030 A shared package SHALL hold the state encoding, the opcode constants (READ=2'b10, WRITE=2'b01) and the synchronizer depth.
REQ-031 The MDC/MDIO synchronizer and edge detect SHALL be sub-module mdio_sync; the IOBUF stays at top level, outside this block.

Verification
REQ-032 Preamble 32x1, ST 01, OP 10, PHYAD 1, REGAD 5'h02, REG_RD_DATA=16'h0141 -> one REG_RD_STB, REG_ADDR=2; on MDIO, TA Z,0 then 0x0141 MSB first; MDIO_T=1 after the last bit.
REQ-033 Write frame PHYAD 1, REGAD 5'h00, data 16'h8000 -> exactly one REG_WR_STB with REG_WR_DATA=16'h8000, REG_ADDR=0; MDIO_T=1 throughout.
REQ-034 Read frame with PHYAD 3 -> no strobe, MDIO_T=1 for the whole frame.
REQ-035 Preamble of only 31 ones, then a valid frame -> ignored; a following frame with a 32-one preamble -> answered.
REQ-036 OP 11 frame -> ignored; a back-to-back valid read (32-one preamble) -> answered correctly.
REQ-037 SYS_RST_N pulsed low during RDATA bit 8 -> MDIO_T=1 within the reset; no strobes; the next full frame -> answered.
